lfsr_checker: RTL and testbench
===============================

Name: lfsr_checker

Overview:
- Receive-side companion to the 8-bit programmable-tap LFSR stepper.
- Consumes a stream of 8-bit LFSR states produced by a generator and seeds itself from that stream.
- Predicts each next state, declares lock after a run of correct predictions, then counts errors while locked.
- Sits at the sink end of any LFSR-driven path, for example noise or sequence verification, and provides lock/error status to control logic.

Parameters:
- LOCK_COUNT, 4, consecutive correct predictions required in VERIFY to enter LOCKED (1..255).
- UNLOCK_COUNT, 3, consecutive mispredictions in LOCKED that force HUNT (1..255).
- DEFAULT_TAPS, 8'hB8, tap register value after reset.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- tapEn  in  1  load tap register from tapData this cycle.
- tapData  in  8  new tap mask.
- np  in  1  step direction: 1 = next (forward), 0 = previous (reverse).
- in_valid  in  1  in_data holds a sample this cycle.
- in_data  in  8  received LFSR state.
- clear  in  1  synchronous clear: err_count <= 0, state <= HUNT.
- locked  out  1  1 while state == LOCKED.
- state  out  2  0 = HUNT, 1 = VERIFY, 2 = LOCKED.
- expected  out  8  current predicted next sample.
- match_pulse  out  1  one-cycle pulse: the previous sample matched (VERIFY or LOCKED).
- err_pulse  out  1  one-cycle pulse: the previous sample mismatched while LOCKED.
- err_count  out  16  saturating mismatch count in LOCKED.

Behaviour:
- Reset (async, rst_n low): taps = DEFAULT_TAPS; state = HUNT; expected = 0; locked = 0; match_pulse = 0; err_pulse = 0; err_count = 0; internal run counters = 0.
- Step function F(x), combinational, 8-bit:
  - np = 1: F(x) = {x[6:0], ^(x & taps)}.
  - np = 0 and taps[7] = 1: F(x) = {(^((taps<<1) & x)) ^ x[0], x[7:1]}; taps<<1 is truncated to 8 bits.
  - np = 0 and taps[7] = 0: F(x) = {1'b0, x[7:1]}.
  - np is sampled each cycle; a direction change takes effect on the next sample without resetting state.
- All outputs are registered. A sample accepted at edge N produces its pulses, state and expected at edge N; they are visible in cycle N+1.
- Pulses are 0 in every cycle with no accepted sample.
- Priority, highest first: rst_n > clear > tapEn > in_valid.
  - clear: state <= HUNT, err_count <= 0, run counters <= 0; any in_valid sample that cycle is discarded.
  - tapEn: taps <= tapData, state <= HUNT, run counters <= 0; err_count is kept; any sample that cycle is discarded.
- HUNT, on in_valid:
  - in_data == 0 (lockup state): ignored, stay HUNT.
  - otherwise: expected <= F(in_data), match run <= 0, go VERIFY.
- VERIFY, on in_valid:
  - in_data == expected: match_pulse, match run +1, expected <= F(in_data); on reaching LOCK_COUNT go LOCKED and clear the miss run.
  - mismatch with in_data != 0: reseed, expected <= F(in_data), match run <= 0, stay VERIFY.
  - mismatch with in_data == 0: go HUNT.
  - err_count is never touched in VERIFY.
- LOCKED, on in_valid:
  - match: match_pulse, miss run <= 0, expected <= F(expected).
  - mismatch: err_pulse, err_count + 1 saturating at 16'hFFFF, miss run + 1, expected <= F(expected) (flywheel, no reseed).
  - on the miss run reaching UNLOCK_COUNT: go HUNT, locked drops.
- locked follows state; state 3 is unreachable and recovers to HUNT.
- Reset asserted mid-operation returns everything to reset values immediately, including taps.

Test Plan:
- Lock acquisition, taps B8, np = 1, LOCK_COUNT = 4: feed 01, 02, 04, 08, 11 on consecutive cycles -> state goes HUNT -> VERIFY after 01; four match_pulses; locked = 1 the cycle after 11; expected = 23.
- Reverse direction, np = 0, taps B8: feed 47, 23, 11, 08, 04 -> locked = 1; expected = 02 (checks F reverse: 47 -> 23 -> 11).
- Flywheel error: locked with expected = 23, feed 00 -> err_pulse, err_count = 1, expected = 47; then feed 47 -> match_pulse, locked stays 1.
- Unlock, UNLOCK_COUNT = 3: locked, feed three wrong bytes (AA, AA, AA) -> err_count = 3, state = HUNT, locked = 0; a later 00 sample is ignored in HUNT.
- Priority: locked, assert tapEn = 1, tapData = 8'h8E with in_valid = 1 in the same cycle -> taps = 8E, state = HUNT, no pulse, err_count unchanged. Next, clear together with in_valid -> err_count = 0, state = HUNT.
- Async reset mid-stream: drop rst_n between clk edges while locked -> locked, state, err_count and expected go to 0 and taps to B8 without a clock edge.

Source files
------------

// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side tracker for an 8-bit programmable-tap LFSR stream.
// Seeds from the incoming samples, predicts each next state, declares lock after
// a run of correct predictions and then counts mispredictions while locked.
module lfsr_checker #(
  parameter int         LOCK_COUNT   = 4,
  parameter int         UNLOCK_COUNT = 3,
  parameter logic [7:0] DEFAULT_TAPS = 8'hB8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tapEn,
  input  logic [7:0]  tapData,
  input  logic        np,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        clear,
  output logic        locked,
  output logic [1:0]  state,
  output logic [7:0]  expected,
  output logic        match_pulse,
  output logic        err_pulse,
  output logic [15:0] err_count
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] LOCK_TARGET   = 8'(LOCK_COUNT);
  localparam logic [7:0] UNLOCK_TARGET = 8'(UNLOCK_COUNT);

  state_t     stateQ;
  logic [7:0] taps;
  logic [7:0] matchRun;
  logic [7:0] missRun;
  logic [7:0] matchNext;
  logic [7:0] missNext;
  logic [7:0] stepIn;
  logic [7:0] stepOut;
  logic [7:0] tapsShl;
  logic       sampleHit;
  logic       dataZero;
  logic       stateLegal;

  assign state      = stateQ;
  assign matchNext  = matchRun + 8'd1;
  assign missNext   = missRun + 8'd1;
  assign sampleHit  = (in_data == expected);
  assign dataZero   = (in_data == 8'h00);
  assign stateLegal = (stateQ != 2'd3);
  // While locked the checker flywheels on its own prediction instead of reseeding.
  assign stepIn     = (stateQ == LOCKED) ? expected : in_data;

  // One LFSR step of stepIn in the direction selected by np.
  always_comb begin
    tapsShl = {taps[6:0], 1'b0};
    stepOut = 8'h00;
    if (np) begin
      stepOut = {stepIn[6:0], ^(stepIn & taps)};
    end else if (taps[7]) begin
      stepOut = {(^(tapsShl & stepIn)) ^ stepIn[0], stepIn[7:1]};
    end else begin
      stepOut = {1'b0, stepIn[7:1]};
    end
  end

  // Tracking state machine with registered status, prediction, pulses and error count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps        <= DEFAULT_TAPS;
      stateQ      <= HUNT;
      locked      <= 1'b0;
      expected    <= 8'h00;
      match_pulse <= 1'b0;
      err_pulse   <= 1'b0;
      err_count   <= 16'h0000;
      matchRun    <= 8'h00;
      missRun     <= 8'h00;
    end else begin
      match_pulse <= 1'b0;
      err_pulse   <= 1'b0;
      if (clear) begin
        stateQ    <= HUNT;
        locked    <= 1'b0;
        err_count <= 16'h0000;
        matchRun  <= 8'h00;
        missRun   <= 8'h00;
      end else if (tapEn) begin
        taps     <= tapData;
        stateQ   <= HUNT;
        locked   <= 1'b0;
        matchRun <= 8'h00;
        missRun  <= 8'h00;
      end else if (!stateLegal) begin
        stateQ <= HUNT;
        locked <= 1'b0;
      end else if (in_valid) begin
        case (stateQ)
          HUNT: begin
            if (!dataZero) begin
              expected <= stepOut;
              matchRun <= 8'h00;
              stateQ   <= VERIFY;
            end
          end
          VERIFY: begin
            if (sampleHit) begin
              match_pulse <= 1'b1;
              matchRun    <= matchNext;
              expected    <= stepOut;
              if (matchNext == LOCK_TARGET) begin
                stateQ  <= LOCKED;
                locked  <= 1'b1;
                missRun <= 8'h00;
              end
            end else if (!dataZero) begin
              expected <= stepOut;
              matchRun <= 8'h00;
            end else begin
              stateQ <= HUNT;
            end
          end
          LOCKED: begin
            expected <= stepOut;
            if (sampleHit) begin
              match_pulse <= 1'b1;
              missRun     <= 8'h00;
            end else begin
              err_pulse <= 1'b1;
              if (err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
              end
              missRun <= missNext;
              if (missNext == UNLOCK_TARGET) begin
                stateQ <= HUNT;
                locked <= 1'b0;
              end
            end
          end
          default: begin
            stateQ <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed and randomized checks of lfsr_checker against a
// behavioural model built from the stepping and locking rules.
module tb_lfsr_checker;

  localparam int LOCK_COUNT   = 4;
  localparam int UNLOCK_COUNT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        tapEn = 1'b0;
  logic [7:0]  tapData = 8'h00;
  logic        np = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        clear = 1'b0;
  logic        locked;
  logic [1:0]  state;
  logic [7:0]  expected;
  logic        match_pulse;
  logic        err_pulse;
  logic [15:0] err_count;

  int checks = 0;
  int errors = 0;
  int mpSum  = 0;
  bit dirBit = 1'b1;

  int mTaps, mState, mExp, mMatch, mMiss, mMp, mEp, mErr;

  lfsr_checker #(
    .LOCK_COUNT(LOCK_COUNT),
    .UNLOCK_COUNT(UNLOCK_COUNT),
    .DEFAULT_TAPS(8'hB8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tapEn(tapEn),
    .tapData(tapData),
    .np(np),
    .in_valid(in_valid),
    .in_data(in_data),
    .clear(clear),
    .locked(locked),
    .state(state),
    .expected(expected),
    .match_pulse(match_pulse),
    .err_pulse(err_pulse),
    .err_count(err_count)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Arithmetic form of one LFSR step (parity via bit counting, shifts via * and /).
  function automatic int refStep(input int x, input int tp, input bit fwd);
    if (fwd) return ((x * 2) % 256) + ($countones(x & tp) % 2);
    if (tp >= 128) return (($countones(((tp * 2) % 256) & x) + x) % 2) * 128 + x / 2;
    return x / 2;
  endfunction

  task automatic modelReset();
    mTaps = 8'hB8; mState = 0; mExp = 0; mMatch = 0; mMiss = 0;
    mMp = 0; mEp = 0; mErr = 0;
  endtask

  // Behavioural reference: state codes 0 hunt, 1 verify, 2 locked.
  task automatic modelStep(input bit c, input bit te, input int td, input bit dir,
                           input bit v, input int d);
    mMp = 0;
    mEp = 0;
    if (c) begin
      mState = 0; mErr = 0; mMatch = 0; mMiss = 0;
    end else if (te) begin
      mTaps = td; mState = 0; mMatch = 0; mMiss = 0;
    end else if (v) begin
      if (mState == 0) begin
        if (d != 0) begin
          mExp = refStep(d, mTaps, dir); mMatch = 0; mState = 1;
        end
      end else if (mState == 1) begin
        if (d == mExp) begin
          mMp = 1; mMatch++; mExp = refStep(d, mTaps, dir);
          if (mMatch == LOCK_COUNT) begin
            mState = 2; mMiss = 0;
          end
        end else if (d != 0) begin
          mExp = refStep(d, mTaps, dir); mMatch = 0;
        end else begin
          mState = 0;
        end
      end else begin
        if (d == mExp) begin
          mMp = 1; mMiss = 0;
        end else begin
          mEp = 1; mMiss++;
          if (mErr < 65535) mErr++;
          if (mMiss == UNLOCK_COUNT) mState = 0;
        end
        mExp = refStep(mExp, mTaps, dir);
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, ".state"}, 16'(state), 16'(mState));
    checkOutput({tag, ".locked"}, 16'(locked), 16'(mState == 2));
    checkOutput({tag, ".expected"}, 16'(expected), 16'(mExp));
    checkOutput({tag, ".match_pulse"}, 16'(match_pulse), 16'(mMp));
    checkOutput({tag, ".err_pulse"}, 16'(err_pulse), 16'(mEp));
    checkOutput({tag, ".err_count"}, err_count, 16'(mErr));
  endtask

  // Drive one cycle from a negedge, clock it in, then compare at the next negedge.
  task automatic applyStimulus(input string tag, input bit c, input bit te, input logic [7:0] td,
                               input bit v, input logic [7:0] d);
    clear = c; tapEn = te; tapData = td; np = dirBit; in_valid = v; in_data = d;
    @(posedge clk);
    modelStep(c, te, int'(td), dirBit, v, int'(d));
    @(negedge clk);
    clear = 1'b0; tapEn = 1'b0; in_valid = 1'b0;
    mpSum += int'(match_pulse);
    compareAll(tag);
  endtask

  task automatic feed(input string tag, input logic [7:0] d);
    applyStimulus(tag, 1'b0, 1'b0, 8'h00, 1'b1, d);
  endtask

  task automatic lockForwardB8(input string tag);
    feed(tag, 8'h01); feed(tag, 8'h02); feed(tag, 8'h04); feed(tag, 8'h08); feed(tag, 8'h11);
  endtask

  initial begin
    int x;
    logic [7:0] smp;
    bit c, te, v;
    logic [7:0] td;

    modelReset();
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset.state", 16'(state), 16'h0);
    checkOutput("reset.locked", 16'(locked), 16'h0);
    checkOutput("reset.expected", 16'(expected), 16'h0);
    checkOutput("reset.err_count", err_count, 16'h0);
    checkOutput("reset.pulses", 16'({match_pulse, err_pulse}), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] lock acquisition, forward, taps B8");
    dirBit = 1'b1;
    mpSum = 0;
    feed("acq", 8'h01);
    checkOutput("acq.verify_after_01", 16'(state), 16'h1);
    feed("acq", 8'h02); feed("acq", 8'h04); feed("acq", 8'h08); feed("acq", 8'h11);
    checkOutput("acq.match_pulses", 16'(mpSum), 16'd4);
    checkOutput("acq.locked", 16'(locked), 16'h1);
    checkOutput("acq.expected", 16'(expected), 16'h23);

    $display("[TB] flywheel error");
    feed("fly", 8'h00);
    checkOutput("fly.err_pulse", 16'(err_pulse), 16'h1);
    checkOutput("fly.err_count", err_count, 16'd1);
    checkOutput("fly.expected", 16'(expected), 16'h47);
    feed("fly", 8'h47);
    checkOutput("fly.match_pulse", 16'(match_pulse), 16'h1);
    checkOutput("fly.still_locked", 16'(locked), 16'h1);

    $display("[TB] clear then unlock");
    applyStimulus("clr", 1'b1, 1'b0, 8'h00, 1'b1, 8'h8E);
    checkOutput("clr.err_count", err_count, 16'd0);
    checkOutput("clr.state", 16'(state), 16'h0);
    lockForwardB8("relock1");
    feed("unlock", 8'hAA); feed("unlock", 8'hAA); feed("unlock", 8'hAA);
    checkOutput("unlock.err_count", err_count, 16'd3);
    checkOutput("unlock.state", 16'(state), 16'h0);
    checkOutput("unlock.locked", 16'(locked), 16'h0);
    feed("hunt_zero", 8'h00);
    checkOutput("hunt_zero.state", 16'(state), 16'h0);

    $display("[TB] priority of tapEn and clear over samples");
    lockForwardB8("relock2");
    applyStimulus("prio_tap", 1'b0, 1'b1, 8'h8E, 1'b1, expected);
    checkOutput("prio_tap.state", 16'(state), 16'h0);
    checkOutput("prio_tap.pulses", 16'({match_pulse, err_pulse}), 16'h0);
    checkOutput("prio_tap.err_count", err_count, 16'd3);
    applyStimulus("prio_clr", 1'b1, 1'b0, 8'h00, 1'b1, 8'h55);
    checkOutput("prio_clr.err_count", err_count, 16'd0);
    checkOutput("prio_clr.state", 16'(state), 16'h0);

    $display("[TB] reverse direction");
    applyStimulus("taps_b8", 1'b0, 1'b1, 8'hB8, 1'b0, 8'h00);
    dirBit = 1'b0;
    feed("rev", 8'h47); feed("rev", 8'h23); feed("rev", 8'h11); feed("rev", 8'h08); feed("rev", 8'h04);
    checkOutput("rev.locked", 16'(locked), 16'h1);
    checkOutput("rev.expected", 16'(expected), 16'h02);

    $display("[TB] async reset while locked on taps 8E");
    dirBit = 1'b1;
    applyStimulus("taps_8e", 1'b0, 1'b1, 8'h8E, 1'b0, 8'h00);
    x = 1;
    feed("lock8e", 8'(x));
    for (int i = 0; i < LOCK_COUNT; i++) begin
      x = refStep(x, 8'h8E, 1'b1);
      feed("lock8e", 8'(x));
    end
    checkOutput("lock8e.locked", 16'(locked), 16'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst.locked", 16'(locked), 16'h0);
    checkOutput("arst.state", 16'(state), 16'h0);
    checkOutput("arst.err_count", err_count, 16'h0);
    checkOutput("arst.expected", 16'(expected), 16'h0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    lockForwardB8("arst_relock");
    checkOutput("arst_relock.locked", 16'(locked), 16'h1);
    checkOutput("arst_relock.expected", 16'(expected), 16'h23);

    $display("[TB] randomized stream");
    x = 8'h5A;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) dirBit = ~dirBit;
      c  = ($urandom_range(0, 79) == 0);
      te = ($urandom_range(0, 59) == 0);
      td = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) td[7] = 1'b1;
      v  = ($urandom_range(0, 9) < 8);
      if (v) begin
        x = refStep(x, mTaps, dirBit);
        if (x == 0 || $urandom_range(0, 49) == 0) x = $urandom_range(1, 255);
        smp = 8'(x);
        if ($urandom_range(0, 11) == 0) smp = 8'($urandom_range(0, 255));
      end else begin
        smp = 8'($urandom_range(0, 255));
      end
      applyStimulus("rand", c, te, td, v, smp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
